// File: rtl/intsched_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package intsched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } intsched_state_t;

  localparam logic [3:0] MEI = 4'd11;
  localparam logic [3:0] MSI = 4'd3;
  localparam logic [3:0] MTI = 4'd7;
  localparam logic [3:0] SEI = 4'd9;
  localparam logic [3:0] SSI = 4'd1;
  localparam logic [3:0] STI = 4'd5;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_U = 2'b00;

endpackage

// File: rtl/int_prio_sel.sv
// Fixed-priority picker: returns the highest-priority interrupt in a
// 12-bit pending set, using the order 11, 3, 7, 9, 1, 5.
module int_prio_sel
  import intsched_pkg::*;
(
  input  logic [11:0] set_i,
  output logic        valid_o,
  output logic [3:0]  cause_o
);

  logic unusedBits;

  // Only the six architected interrupt positions take part in selection.
  assign unusedBits = ^{set_i[10], set_i[8], set_i[6], set_i[4], set_i[2], set_i[0]};

  // Walk the bits in priority order and report the first one found.
  always_comb begin
    valid_o = 1'b1;
    cause_o = 4'd0;
    if (set_i[11]) begin
      cause_o = MEI;
    end else if (set_i[3]) begin
      cause_o = MSI;
    end else if (set_i[7]) begin
      cause_o = MTI;
    end else if (set_i[9]) begin
      cause_o = SEI;
    end else if (set_i[1]) begin
      cause_o = SSI;
    end else if (set_i[5]) begin
      cause_o = STI;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sched.sv
// Interrupt entry sequencer: picks the highest-priority takeable interrupt,
// raises a request to the trap logic, and enforces a hold-off window after
// every acknowledged trap so mstatus updates settle before the next request.
module interrupt_sched
  import intsched_pkg::*;
#(
  parameter int HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] MIP_REGW,
  input  logic [11:0] MIE_REGW,
  input  logic [11:0] MIDELEG_REGW,
  input  logic [1:0]  PrivilegeModeW,
  input  logic        STATUS_MIE,
  input  logic        STATUS_SIE,
  input  logic        TrapAckM,
  output logic        IntReqM,
  output logic [3:0]  IntCauseM,
  output logic        IntToSM,
  output logic        WfiWakeM
);

  if (HOLDOFF < 1 || HOLDOFF > 15) begin : gHoldoffRange
    $error("interrupt_sched: HOLDOFF must lie in 1..15");
  end

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

  logic [11:0]     pend;
  logic [11:0]     mSet;
  logic [11:0]     sSet;
  logic            mValid;
  logic            sValid;
  logic [3:0]      mCause;
  logic [3:0]      sCause;
  logic            mEligible;
  logic            sEligible;
  logic            mTake;
  logic            sTake;
  logic            selValid;
  logic [3:0]      selCause;
  logic            selToS;

  intsched_state_t state_q;
  logic [3:0]      count_q;
  logic            intReq_q;
  logic [3:0]      cause_q;
  logic            toS_q;
  logic            wfiWake_q;

  assign pend = MIP_REGW & MIE_REGW;
  assign mSet = pend & ~MIDELEG_REGW;
  assign sSet = pend & MIDELEG_REGW;

  int_prio_sel uMSel (
    .set_i   (mSet),
    .valid_o (mValid),
    .cause_o (mCause)
  );

  int_prio_sel uSSel (
    .set_i   (sSet),
    .valid_o (sValid),
    .cause_o (sCause)
  );

  // M-targeted interrupts are masked only while already in M with MIE clear;
  // S-targeted ones can never preempt M mode.
  always_comb begin
    mEligible = (PrivilegeModeW != PRIV_M) || STATUS_MIE;
    sEligible = (PrivilegeModeW == PRIV_U) ||
                ((PrivilegeModeW == PRIV_S) && STATUS_SIE);
    mTake     = mEligible && mValid;
    sTake     = sEligible && sValid;
    selValid  = mTake || sTake;
    selCause  = mTake ? mCause : sCause;
    selToS    = !mTake;
  end

  // Request/ack FSM with hold-off counter; cause and target are held
  // whenever no request is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      intReq_q  <= 1'b0;
      cause_q   <= 4'd0;
      toS_q     <= 1'b0;
      wfiWake_q <= 1'b0;
    end else begin
      wfiWake_q <= |pend;
      case (state_q)
        IDLE: begin
          if (selValid) begin
            state_q  <= REQ;
            intReq_q <= 1'b1;
            cause_q  <= selCause;
            toS_q    <= selToS;
          end
        end
        REQ: begin
          if (TrapAckM) begin
            state_q  <= HOLD;
            intReq_q <= 1'b0;
            count_q  <= HOLD_LOAD;
          end else if (selValid) begin
            cause_q <= selCause;
            toS_q   <= selToS;
          end else begin
            state_q  <= IDLE;
            intReq_q <= 1'b0;
          end
        end
        HOLD: begin
          intReq_q <= 1'b0;
          if (count_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          intReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign IntReqM   = intReq_q;
  assign IntCauseM = cause_q;
  assign IntToSM   = toS_q;
  assign WfiWakeM  = wfiWake_q;

endmodule

// File: tb/tb_interrupt_sched.sv
// Directed bench for interrupt_sched with hand-computed expectations.
module tb_interrupt_sched;

  logic        clk;
  logic        reset;
  logic [11:0] MIP_REGW;
  logic [11:0] MIE_REGW;
  logic [11:0] MIDELEG_REGW;
  logic [1:0]  PrivilegeModeW;
  logic        STATUS_MIE;
  logic        STATUS_SIE;
  logic        TrapAckM;
  logic        IntReqM;
  logic [3:0]  IntCauseM;
  logic        IntToSM;
  logic        WfiWakeM;

  int compared;
  int mismatched;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] PM = 2'b11;
  localparam logic [1:0] PS = 2'b01;
  localparam logic [1:0] PU = 2'b00;

  interrupt_sched #(.HOLDOFF(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .MIP_REGW       (MIP_REGW),
    .MIE_REGW       (MIE_REGW),
    .MIDELEG_REGW   (MIDELEG_REGW),
    .PrivilegeModeW (PrivilegeModeW),
    .STATUS_MIE     (STATUS_MIE),
    .STATUS_SIE     (STATUS_SIE),
    .TrapAckM       (TrapAckM),
    .IntReqM        (IntReqM),
    .IntCauseM      (IntCauseM),
    .IntToSM        (IntToSM),
    .WfiWakeM       (WfiWakeM)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every DUT input in one go.
  task automatic applyStimulus(input logic [11:0] mip, input logic [11:0] mie,
                               input logic [11:0] mideleg, input logic [1:0] priv,
                               input logic sMie, input logic sSie, input logic ack);
    MIP_REGW       = mip;
    MIE_REGW       = mie;
    MIDELEG_REGW   = mideleg;
    PrivilegeModeW = priv;
    STATUS_MIE     = sMie;
    STATUS_SIE     = sSie;
    TrapAckM       = ack;
  endtask

  // Count one comparison and report it if observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acknowledge the current request with nothing pending and wait out hold-off.
  task automatic drainToIdle();
    applyStimulus(12'h000, 12'h000, 12'h000, PU, 1'b0, 1'b0, 1'b1);
    tick();
    TrapAckM = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Directed scenarios covering selection, handshake, hold-off and reset.
  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(12'h000, 12'h000, 12'h000, PU, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_req",   32'(IntReqM),   32'd0);
    checkOutput("rst_cause", 32'(IntCauseM), 32'd0);
    checkOutput("rst_tos",   32'(IntToSM),   32'd0);
    checkOutput("rst_wfi",   32'(WfiWakeM),  32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] scenario 1: U mode MTI, ack and hold-off");
    applyStimulus(12'h080, 12'h080, 12'h000, PU, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("s1_req",   32'(IntReqM),   32'd1);
    checkOutput("s1_cause", 32'(IntCauseM), 32'd7);
    checkOutput("s1_tos",   32'(IntToSM),   32'd0);
    checkOutput("s1_wfi",   32'(WfiWakeM),  32'd1);
    TrapAckM = 1'b1;
    tick();
    TrapAckM = 1'b0;
    checkOutput("s1_hold1", 32'(IntReqM), 32'd0);
    checkOutput("s1_state", 32'(dut.state_q), 32'(ST_HOLD));
    tick();
    checkOutput("s1_hold2", 32'(IntReqM), 32'd0);
    tick();
    checkOutput("s1_idle",  32'(IntReqM), 32'd0);
    tick();
    checkOutput("s1_rereq", 32'(IntReqM),   32'd1);
    checkOutput("s1_recau", 32'(IntCauseM), 32'd7);
    drainToIdle();
    checkOutput("s1_drain", 32'(dut.state_q), 32'(ST_IDLE));
    checkOutput("s1_wfi0",  32'(WfiWakeM),    32'd0);

    $display("[TB] scenario 2: delegated STI then MEI preempts");
    applyStimulus(12'h020, 12'hAAA, 12'h222, PS, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("s2_req",   32'(IntReqM),   32'd1);
    checkOutput("s2_cause", 32'(IntCauseM), 32'd5);
    checkOutput("s2_tos",   32'(IntToSM),   32'd1);
    MIP_REGW = 12'h820;
    tick();
    checkOutput("s2_req2",   32'(IntReqM),   32'd1);
    checkOutput("s2_cause2", 32'(IntCauseM), 32'd11);
    checkOutput("s2_tos2",   32'(IntToSM),   32'd0);
    drainToIdle();

    $display("[TB] scenario 3: M mode with MIE clear stays quiet");
    applyStimulus(12'h888, 12'h888, 12'h000, PM, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("s3_req",  32'(IntReqM),  32'd0);
    checkOutput("s3_wfi",  32'(WfiWakeM), 32'd1);
    TrapAckM = 1'b1;
    tick();
    TrapAckM = 1'b0;
    checkOutput("s3_ackig", 32'(dut.state_q), 32'(ST_IDLE));
    STATUS_MIE = 1'b1;
    tick();
    checkOutput("s3_mie",   32'(IntReqM),   32'd1);
    checkOutput("s3_cause", 32'(IntCauseM), 32'd11);
    drainToIdle();

    $display("[TB] scenario 4: selection vanishes in REQ");
    applyStimulus(12'h200, 12'h200, 12'h000, PU, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("s4_cause", 32'(IntCauseM), 32'd9);
    MIE_REGW = 12'h000;
    tick();
    checkOutput("s4_drop",  32'(IntReqM),     32'd0);
    checkOutput("s4_idle",  32'(dut.state_q), 32'(ST_IDLE));
    checkOutput("s4_held",  32'(IntCauseM),   32'd9);
    MIE_REGW = 12'h200;
    tick();
    checkOutput("s4_req2",  32'(IntReqM), 32'd1);
    MIE_REGW = 12'h000;
    TrapAckM = 1'b1;
    tick();
    TrapAckM = 1'b0;
    checkOutput("s4_hold",  32'(dut.state_q), 32'(ST_HOLD));
    checkOutput("s4_req3",  32'(IntReqM),     32'd0);
    tick();
    tick();
    checkOutput("s4_back",  32'(dut.state_q), 32'(ST_IDLE));

    $display("[TB] scenario 5: S set ineligible in M mode");
    applyStimulus(12'h002, 12'h002, 12'h002, PM, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("s5_req1", 32'(IntReqM),  32'd0);
    tick();
    checkOutput("s5_req2", 32'(IntReqM),  32'd0);
    checkOutput("s5_wfi",  32'(WfiWakeM), 32'd1);

    $display("[TB] scenario 6: async reset in HOLD");
    applyStimulus(12'h800, 12'h800, 12'h000, PU, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("s6_req", 32'(IntReqM), 32'd1);
    TrapAckM = 1'b1;
    tick();
    TrapAckM = 1'b0;
    checkOutput("s6_hold", 32'(dut.state_q), 32'(ST_HOLD));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s6_rreq",   32'(IntReqM),     32'd0);
    checkOutput("s6_rcause", 32'(IntCauseM),   32'd0);
    checkOutput("s6_rtos",   32'(IntToSM),     32'd0);
    checkOutput("s6_rwfi",   32'(WfiWakeM),    32'd0);
    checkOutput("s6_rstate", 32'(dut.state_q), 32'(ST_IDLE));
    checkOutput("s6_rcnt",   32'(dut.count_q), 32'd0);
    #2;
    reset = 1'b0;
    tick();
    checkOutput("s6_req2",   32'(IntReqM),   32'd1);
    checkOutput("s6_cause2", 32'(IntCauseM), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
